// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and video types
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int HS_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
  localparam int VS_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

  typedef logic [23:0] rgb24_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  function automatic logic [9:0] to_cnt(input int value);
    return 10'(value);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster scan, colour return and VGA DAC pin bundle
interface vga_timing_gen_if;
  import vga_pkg::*;

  rgb24_t     Pixel_Color;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_clk;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    input  Pixel_Color,
    output DrawX, DrawY, frame_clk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
    output VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output Pixel_Color,
    input  DrawX, DrawY, frame_clk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  VGA_R, VGA_G, VGA_B
  );

endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with synchronous clear to an idle value
module vga_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= IDLE;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/blank pipeline and DAC colour output
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int PIPE_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_LAST   = to_cnt(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = to_cnt(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_FIRST = to_cnt(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = to_cnt(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = to_cnt(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = to_cnt(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = to_cnt(H_VISIBLE);
  localparam logic [9:0] V_VIS    = to_cnt(V_VISIBLE);

  logic       r_vga_clk;
  logic [9:0] r_h;
  logic [9:0] r_v;
  rgb24_t     r_rgb;
  vga_ctrl_t  w_ctrl_raw;
  vga_ctrl_t  w_ctrl;
  logic       w_tick;

  // The pixel tick is the Clk cycle in which VGA_CLK is high, so updates land on its falling edge.
  assign w_tick = r_vga_clk;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_vga_clk <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_rgb     <= '0;
    end else begin
      r_vga_clk <= ~r_vga_clk;
      if (w_tick) begin
        r_rgb <= vga.Pixel_Color;
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  assign w_ctrl_raw.hs      = !((r_h >= HS_FIRST) && (r_h <= HS_LAST));
  assign w_ctrl_raw.vs      = !((r_v >= VS_FIRST) && (r_v <= VS_LAST));
  assign w_ctrl_raw.blank_n = (r_h < H_VIS) && (r_v < V_VIS);

  vga_delay_line #(
    .WIDTH ($bits(vga_ctrl_t)),
    .DEPTH (PIPE_STAGES),
    .IDLE  (CTRL_IDLE)
  ) u_ctrl_delay (
    .i_clk   (Clk),
    .i_clr_n (Reset_n),
    .i_en    (w_tick),
    .i_d     (w_ctrl_raw),
    .o_q     (w_ctrl)
  );

  assign vga.DrawX       = r_h;
  assign vga.DrawY       = r_v;
  assign vga.VGA_CLK     = r_vga_clk;
  assign vga.VGA_HS      = w_ctrl.hs;
  assign vga.VGA_VS      = w_ctrl.vs;
  assign vga.frame_clk   = w_ctrl.vs;
  assign vga.VGA_BLANK_N = w_ctrl.blank_n;
  assign vga.VGA_R       = w_ctrl.blank_n ? r_rgb[23:16] : 8'd0;
  assign vga.VGA_G       = w_ctrl.blank_n ? r_rgb[15:8]  : 8'd0;
  assign vga.VGA_B       = w_ctrl.blank_n ? r_rgb[7:0]   : 8'd0;

endmodule
